spw_rx_char_decoder: RTL



---
 rtl/spw_pkg.sv | 22 ++
 rtl/spw_rx_char_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spw_pkg.sv
// Shared SpaceWire receive definitions: control codes, decoder states, NULL hunt pattern.
package spw_pkg;

  // Control character codes, packed as {C0, C1} in transmission order
  localparam logic [1:0] C_FCT = 2'b00;
  localparam logic [1:0] C_EOP = 2'b01;
  localparam logic [1:0] C_EEP = 2'b10;
  localparam logic [1:0] C_ESC = 2'b11;

  // One-hot decoder states
  localparam int unsigned ST_W = 6;
  localparam logic [ST_W-1:0] S_HUNT  = 6'b000001;
  localparam logic [ST_W-1:0] S_PAR   = 6'b000010;
  localparam logic [ST_W-1:0] S_FLAG  = 6'b000100;
  localparam logic [ST_W-1:0] S_CTRL  = 6'b001000;
  localparam logic [ST_W-1:0] S_DATA  = 6'b010000;
  localparam logic [ST_W-1:0] S_ERROR = 6'b100000;

  // Oldest-first: ESC body (1,1,1), FCT parity 0, FCT flag 1, FCT code 0,0
  localparam logic [6:0] NULL_PATTERN = 7'b1110100;

endpackage

// File: rtl/spw_rx_char_decoder.sv
// SpaceWire receive character decoder: hunts for the first NULL, then frames
// characters, checks odd parity across character boundaries and reports
// FCT / N-Char / time-code events plus a sticky error to the link FSM.
//
// state | meaning
// HUNT  | shifting bits, waiting for the first NULL
// PAR   | next bit is the parity bit of a new character
// FLAG  | next bit is the data/control flag; parity checked here
// CTRL  | collecting the 2 control-code bits
// DATA  | collecting the 8 data bits, LSB first
// ERROR | parity or escape violation; held until a reset
module spw_rx_char_decoder
  import spw_pkg::*;
(
  input  logic       pclk,
  input  logic       resetn,
  input  logic       rx_resetn,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       rx_got_bit,
  output logic       rx_got_null,
  output logic       rx_got_fct,
  output logic       rx_got_nchar,
  output logic [8:0] rx_data,
  output logic       rx_got_time_code,
  output logic [7:0] rx_time_code,
  output logic       rx_error
);

  logic [ST_W-1:0] r_state;
  logic [5:0]      r_hunt;   // last six bits seen while hunting, oldest at [5]
  logic [6:0]      r_body;   // body bits shifted in at [6], LSB-first data lands at [0]
  logic [3:0]      r_cnt;    // body bits still to receive, down-counter
  logic            r_par;    // parity bit of the character in flight
  logic            r_prev;   // XOR of the previous character's body bits
  logic            r_acc;    // running XOR of the current body bits
  logic            r_esc;    // ESC received, next character completes NULL or time code

  logic       w_clear;
  logic       w_last;
  logic [6:0] w_hunt_win;
  logic [1:0] w_code;
  logic [7:0] w_byte;

  assign w_clear    = !resetn || !rx_resetn;
  assign w_last     = (r_cnt == 4'd1);
  assign w_hunt_win = {r_hunt, bit_in};
  assign w_code     = {r_body[6], bit_in};
  assign w_byte     = {bit_in, r_body};

  // Character framing, parity check, decode and registered event outputs
  always_ff @(posedge pclk) begin
    if (w_clear) begin
      r_state          <= S_HUNT;
      r_hunt           <= '0;
      r_body           <= '0;
      r_cnt            <= '0;
      r_par            <= 1'b0;
      r_prev           <= 1'b0;
      r_acc            <= 1'b0;
      r_esc            <= 1'b0;
      rx_got_bit       <= 1'b0;
      rx_got_null      <= 1'b0;
      rx_got_fct       <= 1'b0;
      rx_got_nchar     <= 1'b0;
      rx_data          <= '0;
      rx_got_time_code <= 1'b0;
      rx_time_code     <= '0;
      rx_error         <= 1'b0;
    end else begin
      rx_got_bit       <= 1'b0;
      rx_got_fct       <= 1'b0;
      rx_got_nchar     <= 1'b0;
      rx_got_time_code <= 1'b0;
      if (bit_valid && (r_state != S_ERROR)) begin
        rx_got_bit <= 1'b1;
        case (r_state)
          S_HUNT: begin
            r_hunt <= w_hunt_win[5:0];
            if (w_hunt_win == NULL_PATTERN) begin
              // The NULL's FCT has code bits 0,0, so the next parity sees 0
              rx_got_null <= 1'b1;
              r_prev      <= 1'b0;
              r_esc       <= 1'b0;
              r_state     <= S_PAR;
            end
          end
          S_PAR: begin
            r_par   <= bit_in;
            r_state <= S_FLAG;
          end
          S_FLAG: begin
            if ((r_par ^ bit_in ^ r_prev) != 1'b1) begin
              r_state  <= S_ERROR;
              rx_error <= 1'b1;
            end else begin
              r_acc   <= 1'b0;
              r_cnt   <= bit_in ? 4'd2 : 4'd8;
              r_state <= bit_in ? S_CTRL : S_DATA;
            end
          end
          S_CTRL: begin
            r_body <= {bit_in, r_body[6:1]};
            r_acc  <= r_acc ^ bit_in;
            r_cnt  <= r_cnt - 4'd1;
            if (w_last) begin
              r_prev  <= r_acc ^ bit_in;
              r_state <= S_PAR;
              case (w_code)
                C_FCT: begin
                  if (r_esc) r_esc <= 1'b0;
                  else       rx_got_fct <= 1'b1;
                end
                C_EOP, C_EEP: begin
                  if (r_esc) begin
                    r_state  <= S_ERROR;
                    rx_error <= 1'b1;
                  end else begin
                    rx_got_nchar <= 1'b1;
                    rx_data      <= {1'b1, 7'b0, (w_code == C_EEP)};
                  end
                end
                C_ESC: begin
                  if (r_esc) begin
                    r_state  <= S_ERROR;
                    rx_error <= 1'b1;
                  end else begin
                    r_esc <= 1'b1;
                  end
                end
              endcase
            end
          end
          S_DATA: begin
            r_body <= {bit_in, r_body[6:1]};
            r_acc  <= r_acc ^ bit_in;
            r_cnt  <= r_cnt - 4'd1;
            if (w_last) begin
              r_prev  <= r_acc ^ bit_in;
              r_state <= S_PAR;
              if (r_esc) begin
                r_esc            <= 1'b0;
                rx_got_time_code <= 1'b1;
                rx_time_code     <= w_byte;
              end else begin
                rx_got_nchar <= 1'b1;
                rx_data      <= {1'b0, w_byte};
              end
            end
          end
          default: begin
            // Unreachable encodings fail safe into the error trap
            r_state  <= S_ERROR;
            rx_error <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
